// File: rtl/fp_pkg.sv
// fp_pkg: shared definitions for the FP post-normalization stage.
// Provides field widths, the saturated exponent code, the normalizer
// state encoding and the bit positions of the ALU {N,Z,C,V} flag nibble.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Flag nibble layout, MSB first: {N, Z, C, V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/fp_normalizer_if.sv
// fp_normalizer_if: handshake bundle between the FP adder, the normalizer
// and its consumer.
//   in_valid/in_ready : raw sum handshake (sign, exponent, 25-bit mantissa)
//   out_valid/out_ready : packed IEEE-754 single plus {N,Z,C,V} flags
// Modports:
//   master : the side that drives raw sums and consumes results
//   slave  : the normalizer itself
interface fp_normalizer_if;
  import fp_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic               in_sign;
  logic [EXP_W-1:0]   in_exp;
  logic [MAN_W+1:0]   in_man;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic [3:0]         out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_man, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );

endinterface

// File: rtl/fp_normalizer.sv
// fp_normalizer: iterative post-normalization of a raw floating-point sum.
// A captured sum is right-shifted once on carry-out, otherwise left-shifted
// one bit per cycle until the hidden bit is set or the denormal floor is
// reached, then packed as an IEEE-754 single with an {N,Z,C,V} flag nibble.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   reset : synchronous active-high reset
//   bus   : fp_normalizer_if.slave (input and output handshakes)
module fp_normalizer
  import fp_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fp_normalizer_if.slave bus
);

  norm_state_t      state, state_next;

  logic             sign_q;
  logic [MAN_W+1:0] man_q;
  logic [EXP_W:0]   exp_q;      // one extra bit so the carry increment cannot wrap
  logic             special_q;
  logic             ovf_q;

  logic             out_valid_q;
  logic [31:0]      out_result_q;
  logic [3:0]       out_flags_q;

  logic             accept;
  logic             norm_stop;
  logic [EXP_W:0]   exp_inc;
  logic [EXP_W-1:0] pack_exp;
  logic [MAN_W-1:0] pack_frac;
  logic [31:0]      pack_result;
  logic [3:0]       pack_flags;

  // Ready is withheld during reset so nothing is captured on a reset edge.
  assign bus.in_ready   = (state == IDLE) && !reset;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_flags  = out_flags_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign exp_inc = exp_q + 9'd1;

  // Any of these conditions ends normalization in the current cycle.
  assign norm_stop = special_q || (man_q == '0) || man_q[MAN_W+1] ||
                     man_q[MAN_W] || (exp_q <= 9'd1);

  // Result packing. Specials and overflow saturate the exponent; a mantissa
  // without the hidden bit is a denormal and gets a zero exponent field.
  always_comb begin
    pack_exp  = '0;
    pack_frac = man_q[MAN_W-1:0];
    if (special_q || ovf_q) begin
      pack_exp = EXP_MAX;
    end else if (man_q[MAN_W]) begin
      pack_exp = exp_q[EXP_W-1:0];
    end
    if (ovf_q && !special_q) begin
      pack_frac = '0;
    end
    pack_result = {sign_q, pack_exp, pack_frac};
    pack_flags         = '0;
    pack_flags[FLAG_N] = pack_result[31];
    pack_flags[FLAG_Z] = (pack_result[30:0] == '0);
    pack_flags[FLAG_C] = 1'b0;
    pack_flags[FLAG_V] = ovf_q && !special_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one normalization decision per NORM cycle, and DONE
  // is left only on a completed output handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)                            state_next = NORM;
      NORM: if (norm_stop)                         state_next = DONE;
      DONE: if (out_valid_q && bus.out_ready)      state_next = IDLE;
      default:                                     state_next = IDLE;
    endcase
  end

  // Working registers. The first DONE cycle packs the result into the output
  // registers; they then hold until the consumer takes them.
  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q       <= 1'b0;
      man_q        <= '0;
      exp_q        <= '0;
      special_q    <= 1'b0;
      ovf_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_flags_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q    <= bus.in_sign;
            man_q     <= bus.in_man;
            exp_q     <= (bus.in_exp == '0) ? 9'd1 : {1'b0, bus.in_exp};
            special_q <= (bus.in_exp == EXP_MAX);
            ovf_q     <= 1'b0;
          end
        end
        NORM: begin
          if (special_q) begin
            // passes through untouched
          end else if (man_q == '0) begin
            sign_q <= 1'b0;
          end else if (man_q[MAN_W+1]) begin
            man_q <= {1'b0, man_q[MAN_W+1:1]};
            exp_q <= exp_inc;
            if (exp_inc >= {1'b0, EXP_MAX}) begin
              ovf_q <= 1'b1;
            end
          end else if (man_q[MAN_W] || (exp_q <= 9'd1)) begin
            // normalized or at the denormal floor
          end else begin
            man_q <= {man_q[MAN_W:0], 1'b0};
            exp_q <= exp_q - 9'd1;
          end
        end
        DONE: begin
          if (!out_valid_q) begin
            out_result_q <= pack_result;
            out_flags_q  <= pack_flags;
            out_valid_q  <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalizer.sv
// tb_fp_normalizer: directed, table-driven bench for fp_normalizer plus
// hand-written backpressure and mid-operation reset sequences.
module tb_fp_normalizer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  fp_normalizer_if bus_if ();

  fp_normalizer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sign;
    logic [7:0]  exp;
    logic [24:0] man;
    logic [31:0] result;
    logic [3:0]  flags;
    int          latency;
  } vec_t;

  vec_t vecs[11];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Waits for in_ready, presents one raw sum for exactly one accept edge,
  // and returns at the negedge following the accept edge.
  task automatic apply_stimulus(input logic sign, input logic [7:0] exp,
                                input logic [24:0] man);
    int guard = 0;
    @(negedge clk);
    while (!bus_if.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_output("in_ready_before_accept", 32'(bus_if.in_ready), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.in_sign  = sign;
    bus_if.in_exp   = exp;
    bus_if.in_man   = man;
    @(posedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen, bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus_if.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    logic [31:0] held_result;
    logic [3:0]  held_flags;
    logic        stable;

    vecs[0]  = '{1'b0, 8'h7F, 25'h1800000, 32'h40400000, 4'b0000, 2};
    vecs[1]  = '{1'b0, 8'h7F, 25'h0000001, 32'h34000000, 4'b0000, 25};
    vecs[2]  = '{1'b1, 8'h80, 25'h0000000, 32'h00000000, 4'b0100, 2};
    vecs[3]  = '{1'b0, 8'h02, 25'h0200000, 32'h00400000, 4'b0000, 3};
    vecs[4]  = '{1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 4'b0001, 2};
    vecs[5]  = '{1'b1, 8'h00, 25'h0800001, 32'h80800001, 4'b1000, 2};
    vecs[6]  = '{1'b1, 8'hFF, 25'h0400000, 32'hFFC00000, 4'b1000, 2};
    vecs[7]  = '{1'b0, 8'hFF, 25'h1000000, 32'h7F800000, 4'b0000, 2};
    vecs[8]  = '{1'b1, 8'h81, 25'h0A00000, 32'hC0A00000, 4'b1000, 2};
    vecs[9]  = '{1'b0, 8'h00, 25'h0000100, 32'h00000100, 4'b0000, 2};
    vecs[10] = '{1'b0, 8'h85, 25'h0100000, 32'h41000000, 4'b0000, 5};

    bus_if.in_valid  = 1'b0;
    bus_if.in_sign   = 1'b0;
    bus_if.in_exp    = '0;
    bus_if.in_man    = '0;
    bus_if.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_out_valid",  32'(bus_if.out_valid), 32'd0);
    check_output("reset_out_result", bus_if.out_result,     32'h0);
    check_output("reset_out_flags",  32'(bus_if.out_flags), 32'h0);
    check_output("reset_in_ready",   32'(bus_if.in_ready),  32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("idle_in_ready", 32'(bus_if.in_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      apply_stimulus(vecs[i].sign, vecs[i].exp, vecs[i].man);
      wait_valid(lat);
      check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].latency));
      check_output($sformatf("vec%0d_result", i), bus_if.out_result, vecs[i].result);
      check_output($sformatf("vec%0d_flags", i), 32'(bus_if.out_flags), 32'(vecs[i].flags));
      check_output($sformatf("vec%0d_busy_ready", i), 32'(bus_if.in_ready), 32'd0);
      bus_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus_if.out_ready = 1'b0;
      check_output($sformatf("vec%0d_valid_drop", i), 32'(bus_if.out_valid), 32'd0);
      check_output($sformatf("vec%0d_back_idle", i), 32'(bus_if.in_ready), 32'd1);
    end

    // Backpressure: outputs hold for 10 cycles, a competing input is ignored
    apply_stimulus(1'b0, 8'h7F, 25'h1800000);
    wait_valid(lat);
    check_output("bp_latency", 32'(lat), 32'd2);
    held_result = bus_if.out_result;
    held_flags  = bus_if.out_flags;
    check_output("bp_result", held_result, 32'h40400000);
    bus_if.in_valid = 1'b1;
    bus_if.in_sign  = 1'b1;
    bus_if.in_exp   = 8'h80;
    bus_if.in_man   = 25'h0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      stable = bus_if.out_valid && !bus_if.in_ready &&
               (bus_if.out_result == held_result) && (bus_if.out_flags == held_flags);
      check_output($sformatf("bp_hold_cycle%0d", c), 32'(stable), 32'd1);
    end
    check_output("bp_held_result", bus_if.out_result, 32'h40400000);
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check_output("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
    check_output("bp_release_ready", 32'(bus_if.in_ready), 32'd1);

    // Reset during NORM: nothing may be emitted afterwards
    apply_stimulus(1'b0, 8'h7F, 25'h0000001);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("rst_norm_valid", 32'(bus_if.out_valid), 32'd0);
    check_output("rst_norm_ready_in_reset", 32'(bus_if.in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check_output("rst_norm_ready_after", 32'(bus_if.in_ready), 32'd1);
    stable = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus_if.out_valid) stable = 1'b0;
    end
    check_output("rst_norm_no_result", 32'(stable), 32'd1);

    // Reset during DONE: pending result discarded
    bus_if.out_ready = 1'b0;
    apply_stimulus(1'b1, 8'h81, 25'h0A00000);
    wait_valid(lat);
    check_output("rst_done_pre_valid", 32'(bus_if.out_valid), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("rst_done_valid", 32'(bus_if.out_valid), 32'd0);
    check_output("rst_done_result", bus_if.out_result, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_done_ready", 32'(bus_if.in_ready), 32'd1);

    // Normal operation after reset
    apply_stimulus(1'b0, 8'h02, 25'h0200000);
    wait_valid(lat);
    check_output("post_rst_latency", 32'(lat), 32'd3);
    check_output("post_rst_result", bus_if.out_result, 32'h00400000);
    bus_if.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.out_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
